iterate_sqrt_pipe: RTL

- Parametrised successor to the fixed 11-bit iterative square-root unit.
- Computes a correctly rounded (round-to-nearest) square root of one floating value with configurable significand and exponent widths.
- Inputs use a valid/ready handshake and outputs are held under backpressure.
- Optional per-iteration trace port. Sits between the number unpacker and the result packer in the FP datapath.

---
 rtl/iterate_sqrt_pipe.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/iterate_sqrt_pipe.sv
// Iterative restoring square root for unpacked floating values.
// One root bit per clock plus a guard bit, then a single rounding step.
`timescale 1ns/1ps
module iterate_sqrt_pipe #(
  parameter int MANT_W   = 11,
  parameter int EXP_W    = 7,
  parameter int EXP_ZERO = -15,
  parameter int EXP_INF  = 16,
  parameter int TRACE    = 1
) (
  input  logic                    clk,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign_in,
  input  logic signed [EXP_W-1:0] exp_in,
  input  logic [MANT_W-1:0]       mant_in,
  input  logic                    is_nan_in,
  input  logic                    is_pinf_in,
  input  logic                    is_ninf_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sign_out,
  output logic signed [EXP_W-1:0] exp_out,
  output logic [MANT_W-1:0]       mant_out,
  output logic                    is_nan_out,
  output logic                    is_pinf_out,
  output logic                    is_ninf_out,
  output logic                    step_valid,
  output logic [MANT_W-1:0]       step_mant
);

  localparam int ITERS  = MANT_W + 1;
  localparam int RAD_W  = 2 * ITERS;
  localparam int REM_W  = MANT_W + 3;
  localparam int WIDE_W = REM_W + 2;
  localparam int CNT_W  = $clog2(ITERS + 1);

  localparam logic signed [EXP_W-1:0] EXP_ZERO_C = EXP_ZERO[EXP_W-1:0];
  localparam logic signed [EXP_W-1:0] EXP_INF_C  = EXP_INF[EXP_W-1:0];
  localparam logic signed [EXP_W-1:0] EXP_ONE    = 1;
  localparam logic [MANT_W-1:0]       MANT_ONE   = {1'b1, {(MANT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_INIT   = ITERS[CNT_W-1:0];
  localparam logic [CNT_W-1:0]        CNT_ONE    = 1;

  typedef enum logic [1:0] {IDLE, CALC, ROUND, HOLD} state_t;

  state_t                  state_reg;
  logic [RAD_W-1:0]        rad_reg;
  logic [REM_W-1:0]        rem_reg;
  logic [ITERS-1:0]        root_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic signed [EXP_W-1:0] exp_half_reg;

  assign in_ready = (state_reg == IDLE) && enable;

  // Operand alignment: an odd exponent folds one factor of two into the significand.
  logic                    odd_exp;
  logic [ITERS-1:0]        work;
  logic signed [EXP_W-1:0] exp_half;

  assign odd_exp  = exp_in[0];
  assign work     = odd_exp ? {mant_in, 1'b0} : {1'b0, mant_in};
  assign exp_half = {exp_in[EXP_W-1], exp_in[EXP_W-1:1]};

  // One restoring digit step, compared at full width.
  logic [WIDE_W-1:0] rem_wide;
  logic [WIDE_W-1:0] trial_wide;
  logic [WIDE_W-1:0] diff_wide;
  logic              step_bit;
  logic [ITERS-1:0]  root_step;

  assign rem_wide   = {rem_reg, rad_reg[RAD_W-1 -: 2]};
  assign trial_wide = {{(WIDE_W-ITERS-2){1'b0}}, root_reg, 2'b01};
  assign step_bit   = (rem_wide >= trial_wide);
  assign diff_wide  = step_bit ? (rem_wide - trial_wide) : rem_wide;
  assign root_step  = {root_reg[ITERS-2:0], step_bit};

  logic [MANT_W-1:0] q;
  logic              guard;
  logic [MANT_W:0]   q_rnd;

  assign q     = root_reg[ITERS-1:1];
  assign guard = root_reg[0];
  assign q_rnd = {1'b0, q} + {{MANT_W{1'b0}}, guard};

  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      state_reg    <= IDLE;
      rad_reg      <= '0;
      rem_reg      <= '0;
      root_reg     <= '0;
      cnt_reg      <= '0;
      exp_half_reg <= '0;
      out_valid    <= 1'b0;
      sign_out     <= 1'b0;
      exp_out      <= '0;
      mant_out     <= '0;
      is_nan_out   <= 1'b0;
      is_pinf_out  <= 1'b0;
      is_ninf_out  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (is_nan_in || is_ninf_in) begin
              sign_out    <= 1'b1;
              exp_out     <= EXP_INF_C;
              mant_out    <= MANT_ONE;
              is_nan_out  <= 1'b1;
              is_pinf_out <= 1'b0;
              is_ninf_out <= 1'b0;
              out_valid   <= 1'b1;
              state_reg   <= HOLD;
            end else if (is_pinf_in) begin
              sign_out    <= 1'b0;
              exp_out     <= EXP_INF_C;
              mant_out    <= '0;
              is_nan_out  <= 1'b0;
              is_pinf_out <= 1'b1;
              is_ninf_out <= 1'b0;
              out_valid   <= 1'b1;
              state_reg   <= HOLD;
            end else if (exp_in == EXP_ZERO_C) begin
              // Subnormals flush to a signed zero.
              sign_out    <= sign_in;
              exp_out     <= EXP_ZERO_C;
              mant_out    <= '0;
              is_nan_out  <= 1'b0;
              is_pinf_out <= 1'b0;
              is_ninf_out <= 1'b0;
              out_valid   <= 1'b1;
              state_reg   <= HOLD;
            end else if (sign_in) begin
              sign_out    <= 1'b1;
              exp_out     <= EXP_INF_C;
              mant_out    <= MANT_ONE;
              is_nan_out  <= 1'b1;
              is_pinf_out <= 1'b0;
              is_ninf_out <= 1'b0;
              out_valid   <= 1'b1;
              state_reg   <= HOLD;
            end else begin
              rad_reg      <= {work, {ITERS{1'b0}}};
              rem_reg      <= '0;
              root_reg     <= '0;
              cnt_reg      <= CNT_INIT;
              exp_half_reg <= exp_half;
              state_reg    <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg  <= diff_wide[REM_W-1:0];
          root_reg <= root_step;
          rad_reg  <= rad_reg << 2;
          cnt_reg  <= cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            state_reg <= ROUND;
          end
        end
        ROUND: begin
          // The guard bit alone decides rounding since sqrt never lands on a tie.
          if (q_rnd[MANT_W]) begin
            mant_out <= MANT_ONE;
            exp_out  <= exp_half_reg + EXP_ONE;
          end else begin
            mant_out <= q_rnd[MANT_W-1:0];
            exp_out  <= exp_half_reg;
          end
          sign_out    <= 1'b0;
          is_nan_out  <= 1'b0;
          is_pinf_out <= 1'b0;
          is_ninf_out <= 1'b0;
          out_valid   <= 1'b1;
          state_reg   <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    if (TRACE != 0) begin : g_trace
      logic              step_valid_reg;
      logic [MANT_W-1:0] step_mant_reg;
      logic [ITERS-1:0]  root_aligned;

      // Left-align the partial root by the number of digits still to come.
      assign root_aligned = root_step << (cnt_reg - CNT_ONE);

      always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
          step_valid_reg <= 1'b0;
          step_mant_reg  <= '0;
        end else begin
          step_valid_reg <= (state_reg == CALC);
          if (state_reg == CALC) begin
            step_mant_reg <= root_aligned[ITERS-1:1];
          end
        end
      end

      assign step_valid = step_valid_reg;
      assign step_mant  = step_mant_reg;
    end else begin : g_no_trace
      assign step_valid = 1'b0;
      assign step_mant  = '0;
    end
  endgenerate

endmodule
